// File: rtl/gpi_input_conditioner.sv
// gpi_input_conditioner: GPIO pad input conditioner.
// Registers the pad controls, synchronizes DI_I[0], debounces it into FILT_O,
// and optionally produces edge pulses plus a sticky edge interrupt.
// Optional feature macro: GPI_EDGE_IRQ_EN (edge pulses / IRQ). When it is
// undefined, RISE_O/FALL_O/IRQ_O are tied low and no edge flops exist.
module gpi_input_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  input  logic             EN_I,
  input  logic             PU_CFG_I,
  input  logic             PD_CFG_I,
  input  logic [1:0]       STE_CFG_I,
  input  logic [CNT_W-1:0] DEB_LEN_I,
  input  logic [1:0]       EDGE_EN_I,
  input  logic             IRQ_CLR_I,
  input  logic [1:0]       DI_I,
  output logic             IE_O,
  output logic             PU_O,
  output logic             PD_O,
  output logic [1:0]       STE_O,
  output logic             FILT_O,
  output logic             RISE_O,
  output logic             FALL_O,
  output logic             IRQ_O
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // Pad control registers: one-cycle copies of the configuration inputs.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      IE_O  <= 1'b0;
      PU_O  <= 1'b0;
      PD_O  <= 1'b0;
      STE_O <= '0;
    end else begin
      IE_O  <= EN_I;
      PU_O  <= PU_CFG_I;
      PD_O  <= PD_CFG_I;
      STE_O <= STE_CFG_I;
    end
  end

  // Synchronizer chain for the pad data bit; runs regardless of the enable.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], DI_I[0]};
    end
  end

  // Debounce: FILT_O follows sync once it has differed for DEB_LEN_I+1 cycles.
  // EN_I is the next value of IE_O, so gating on it keeps cnt at 0 and FILT_O
  // frozen in exactly the cycles where IE_O reads 0.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      cnt    <= '0;
      FILT_O <= 1'b0;
    end else if (!EN_I) begin
      cnt    <= '0;
    end else if (sync != FILT_O) begin
      if (cnt >= DEB_LEN_I) begin
        FILT_O <= sync;
        cnt    <= '0;
      end else begin
        cnt    <= cnt + CNT_W'(1);
      end
    end else begin
      cnt    <= '0;
    end
  end

`ifdef GPI_EDGE_IRQ_EN
  logic filt_d;

  // Edge detector: one-cycle pulse in the cycle after FILT_O changes.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      filt_d <= 1'b0;
      RISE_O <= 1'b0;
      FALL_O <= 1'b0;
    end else begin
      filt_d <= FILT_O;
      RISE_O <= EN_I &  FILT_O & ~filt_d;
      FALL_O <= EN_I & ~FILT_O &  filt_d;
    end
  end

  // Sticky interrupt: a qualifying edge wins over a simultaneous clear.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      IRQ_O <= 1'b0;
    end else if ((RISE_O & EDGE_EN_I[0]) | (FALL_O & EDGE_EN_I[1])) begin
      IRQ_O <= 1'b1;
    end else if (IRQ_CLR_I) begin
      IRQ_O <= 1'b0;
    end
  end

  logic unused_di;
  assign unused_di = DI_I[1];
`else
  assign RISE_O = 1'b0;
  assign FALL_O = 1'b0;
  assign IRQ_O  = 1'b0;

  logic unused_in;
  assign unused_in = ^{DI_I[1], EDGE_EN_I, IRQ_CLR_I};
`endif

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// tb_gpi_input_conditioner: directed scoreboard bench for gpi_input_conditioner.
// Expectations carry the cycle at which they fall due and are checked then.
module tb_gpi_input_conditioner;

  localparam int unsigned CNT_W = 8;
`ifdef GPI_EDGE_IRQ_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  localparam int S_IE = 0, S_PU = 1, S_PD = 2, S_STE = 3, S_FILT = 4,
                 S_RISE = 5, S_FALL = 6, S_IRQ = 7, S_ALL = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, pu, pd, irq_clr;
  logic [1:0]       ste, edge_en, di;
  logic [CNT_W-1:0] deb_len;
  logic             ie_o, pu_o, pd_o, filt_o, rise_o, fall_o, irq_o;
  logic [1:0]       ste_o;

  typedef struct {
    int         due;
    int         sel;
    logic [8:0] val;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  gpi_input_conditioner #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .CLK_I(clk), .RSTN_I(rst_n), .EN_I(en), .PU_CFG_I(pu), .PD_CFG_I(pd),
    .STE_CFG_I(ste), .DEB_LEN_I(deb_len), .EDGE_EN_I(edge_en),
    .IRQ_CLR_I(irq_clr), .DI_I(di), .IE_O(ie_o), .PU_O(pu_o), .PD_O(pd_o),
    .STE_O(ste_o), .FILT_O(filt_o), .RISE_O(rise_o), .FALL_O(fall_o),
    .IRQ_O(irq_o)
  );

  function automatic logic [8:0] obs(input int sel);
    case (sel)
      S_IE:    return {8'd0, ie_o};
      S_PU:    return {8'd0, pu_o};
      S_PD:    return {8'd0, pd_o};
      S_STE:   return {7'd0, ste_o};
      S_FILT:  return {8'd0, filt_o};
      S_RISE:  return {8'd0, rise_o};
      S_FALL:  return {8'd0, fall_o};
      S_IRQ:   return {8'd0, irq_o};
      default: return {ie_o, pu_o, pd_o, ste_o, filt_o, rise_o, fall_o, irq_o};
    endcase
  endfunction

  task automatic expect_at(input int k, input int sel, input logic [8:0] val,
                           input string tag);
    exp_t e;
    e.due = cyc + k;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic process();
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        logic [8:0] o;
        o = obs(q[i].sel);
        assert (o === q[i].val) begin
          n_pass++;
        end else begin
          n_fail++;
          $error("FAIL %s (cycle %0d) observed=%0h expected=%0h",
                 q[i].tag, cyc, o, q[i].val);
        end
        q.delete(i);
      end
    end
  endtask

  task automatic check_now(input int sel, input logic [8:0] val, input string tag);
    expect_at(0, sel, val, tag);
    process();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      process();
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; pu = 1'b1; pd = 1'b0; ste = 2'b01;
    deb_len = 8'd3; edge_en = 2'b00; irq_clr = 1'b0; di = 2'b11;
    #12;
    check_now(S_ALL, 9'd0, "reset_all_zero");

    // Reset release with DI already high: first update obeys full latency.
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_at(1, S_IE, 9'd1, "rel_ie");
    expect_at(1, S_PU, 9'd1, "rel_pu");
    expect_at(1, S_STE, 9'd1, "rel_ste");
    expect_at(5, S_FILT, 9'd0, "rel_filt_c5");
    expect_at(6, S_FILT, 9'd1, "rel_filt_c6");
    expect_at(7, S_RISE, {8'd0, EDGE}, "rel_rise_c7");
    expect_at(8, S_RISE, 9'd0, "rel_rise_c8");
    expect_at(8, S_IRQ, 9'd0, "rel_irq_masked");
    run(10);

    // Stable fall then stable rise, N=3.
    di = 2'b00;
    expect_at(5, S_FILT, 9'd1, "fall_filt_c5");
    expect_at(6, S_FILT, 9'd0, "fall_filt_c6");
    expect_at(7, S_FALL, {8'd0, EDGE}, "fall_pulse");
    expect_at(7, S_RISE, 9'd0, "fall_no_rise");
    run(10);
    di = 2'b01;
    expect_at(5, S_FILT, 9'd0, "rise_filt_c5");
    expect_at(6, S_FILT, 9'd1, "rise_filt_c6");
    expect_at(7, S_RISE, {8'd0, EDGE}, "rise_pulse");
    expect_at(8, S_RISE, 9'd0, "rise_pulse_end");
    run(10);
    di = 2'b00;
    expect_at(6, S_FILT, 9'd0, "settle_low");
    run(10);

    // Glitch of 3 cycles is rejected.
    di = 2'b01;
    for (int k = 4; k <= 10; k++) expect_at(k, S_FILT, 9'd0, "glitch3_reject");
    run(3);
    di = 2'b00;
    run(9);

    // Glitch of 4 cycles passes, then returns low.
    di = 2'b01;
    expect_at(5, S_FILT, 9'd0, "glitch4_c5");
    expect_at(6, S_FILT, 9'd1, "glitch4_c6");
    expect_at(7, S_RISE, {8'd0, EDGE}, "glitch4_rise");
    expect_at(9, S_FILT, 9'd1, "glitch4_c9");
    expect_at(10, S_FILT, 9'd0, "glitch4_c10");
    run(4);
    di = 2'b00;
    run(10);

    // IRQ only on fall edges.
    edge_en = 2'b10;
    di = 2'b01;
    expect_at(7, S_RISE, {8'd0, EDGE}, "irq_rise_pulse");
    expect_at(8, S_IRQ, 9'd0, "irq_rise_masked_c8");
    expect_at(9, S_IRQ, 9'd0, "irq_rise_masked_c9");
    run(10);
    di = 2'b00;
    expect_at(7, S_FALL, {8'd0, EDGE}, "irq_fall_pulse");
    expect_at(8, S_IRQ, {8'd0, EDGE}, "irq_fall_set");
    run(10);
    irq_clr = 1'b1;
    expect_at(1, S_IRQ, 9'd0, "irq_clear");
    run(1);
    irq_clr = 1'b0;
    di = 2'b01;
    expect_at(8, S_IRQ, 9'd0, "irq_stays_clear");
    run(10);
    di = 2'b00;
    expect_at(7, S_FALL, {8'd0, EDGE}, "irq_fall2_pulse");
    expect_at(8, S_IRQ, {8'd0, EDGE}, "irq_set_beats_clr");
    expect_at(9, S_IRQ, {8'd0, EDGE}, "irq_sticky");
    run(7);
    irq_clr = 1'b1;
    run(1);
    irq_clr = 1'b0;
    run(4);

    // Disable mid-count, then re-enable: full N+1 count restarts.
    di = 2'b01;
    run(4);
    en = 1'b0;
    expect_at(1, S_IE, 9'd0, "dis_ie");
    for (int k = 1; k <= 8; k++) expect_at(k, S_FILT, 9'd0, "dis_filt_held");
    run(8);
    en = 1'b1;
    expect_at(1, S_IE, 9'd1, "en_ie");
    expect_at(3, S_FILT, 9'd0, "en_filt_c3");
    expect_at(4, S_FILT, 9'd1, "en_filt_c4");
    expect_at(5, S_RISE, {8'd0, EDGE}, "en_rise");
    run(8);

    // Pad configuration pass-through, including keeper mode.
    pu = 1'b0; pd = 1'b1; ste = 2'b10;
    expect_at(1, S_PU, 9'd0, "cfg_pu0");
    expect_at(1, S_PD, 9'd1, "cfg_pd1");
    expect_at(1, S_STE, 9'd2, "cfg_ste2");
    run(1);
    pu = 1'b1;
    expect_at(1, S_PU, 9'd1, "keeper_pu");
    expect_at(1, S_PD, 9'd1, "keeper_pd");
    run(2);

    // Lowering DEB_LEN below the running count loads on the next cycle.
    deb_len = 8'd5;
    di = 2'b00;
    expect_at(5, S_FILT, 9'd1, "lower_c5");
    run(5);
    deb_len = 8'd1;
    expect_at(1, S_FILT, 9'd0, "lower_load");
    run(3);

    // N=0 gives SYNC_STAGES+1 latency.
    deb_len = 8'd0;
    di = 2'b01;
    expect_at(2, S_FILT, 9'd0, "n0_c2");
    expect_at(3, S_FILT, 9'd1, "n0_c3");
    run(5);

    // Reset mid-debounce discards the count.
    deb_len = 8'd3;
    di = 2'b00;
    run(10);
    di = 2'b01;
    run(4);
    rst_n = 1'b0;
    #1;
    check_now(S_ALL, 9'd0, "midreset_all_zero");
    run(2);
    rst_n = 1'b1;
    expect_at(1, S_IE, 9'd1, "midreset_ie");
    expect_at(5, S_FILT, 9'd0, "midreset_c5");
    expect_at(6, S_FILT, 9'd1, "midreset_c6");
    run(8);

    while (q.size() > 0) begin
      n_fail++;
      $error("FAIL %s never checked expected=%0h", q[0].tag, q[0].val);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/gpi_input_conditioner.md
GPI_INPUT_CONDITIONER -- requirements
Module: gpi_input_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (min 2).
REQ-002 SHALL have parameter CNT_W, default 8, width of the debounce counter and DEB_LEN_I.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: CLK_I input 1 is the clock, RSTN_I input 1 is the reset.
REQ-004 EN_I  input  1  conditioner enable, also drives pad IE.
REQ-005 PU_CFG_I  input  1  pull-up request for the pad.
REQ-006 PD_CFG_I  input  1  pull-down request for the pad; PU=PD=1 selects keeper mode.
REQ-007 STE_CFG_I  input  2  Schmitt-trigger select for the pad.
REQ-008 DEB_LEN_I  input  CNT_W  debounce length N in cycles; 0 means no debounce.
REQ-009 EDGE_EN_I  input  2  bit0 rise-IRQ enable, bit1 fall-IRQ enable.
REQ-010 IRQ_CLR_I  input  1  single-cycle clear of the sticky IRQ.
REQ-011 DI_I  input  2  pad receiver output (pad DI_O); bit0 is data, bit1 is unused.
REQ-012 IE_O / PU_O / PD_O  output  1 each  pad IE_I / PU_I / PD_I controls.
REQ-013 STE_O  output  2  pad STE_I control.
REQ-014 FILT_O  output  1  synchronized, debounced pad level.
REQ-015 RISE_O / FALL_O  output  1 each  single-cycle pulse on a FILT_O 0->1 / 1->0 transition.
REQ-016 IRQ_O  output  1  sticky edge interrupt.

Function
REQ-017 IE_O, PU_O, PD_O and STE_O SHALL be registered copies of EN_I, PU_CFG_I, PD_CFG_I and STE_CFG_I, valid one cycle after the input changes.
REQ-018 DI_I[0] SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the signal "sync".
REQ-019 Each cycle where sync != FILT_O and cnt >= DEB_LEN_I, FILT_O SHALL load sync and cnt SHALL clear.
REQ-020 Each cycle where sync != FILT_O and cnt < DEB_LEN_I, cnt SHALL increment by 1.
REQ-021 Whenever sync == FILT_O, cnt SHALL clear, so any glitch shorter than N+1 cycles is rejected.
REQ-022 Latency from a stable change on DI_I[0] to FILT_O SHALL be exactly SYNC_STAGES+N+1 cycles; for N=0 it is SYNC_STAGES+1 cycles.
REQ-023 If DEB_LEN_I is lowered below the current cnt, the compare SHALL use >=, and FILT_O updates on the next differing cycle.
REQ-024 cnt SHALL never wrap, because cnt is bounded by DEB_LEN_I.
REQ-025 While IE_O is 0, cnt SHALL be held at 0, FILT_O SHALL hold its value, and no edge pulse SHALL occur.
REQ-026 The sync chain SHALL keep running while IE_O is 0.
REQ-027 RISE_O / FALL_O SHALL pulse for one cycle in the cycle after FILT_O changes.
REQ-028 IRQ_O SHALL set on RISE_O && EDGE_EN_I[0] or on FALL_O && EDGE_EN_I[1], and clear on IRQ_CLR_I.
REQ-029 When set and clear occur in the same cycle, set SHALL win.

Reset
REQ-030 On RSTN_I low, all outputs SHALL be 0 asynchronously: IE_O, PU_O, PD_O, STE_O, FILT_O, RISE_O, FALL_O, IRQ_O.
REQ-031 On RSTN_I low, the sync chain and cnt SHALL clear asynchronously.
REQ-032 Reset asserted mid-debounce SHALL discard the pending count.
REQ-033 After RSTN_I deasserts, the first FILT_O update SHALL obey REQ-022.

Configuration
REQ-034 Macro GPI_EDGE_IRQ_EN SHALL control the edge logic; when defined, RISE_O, FALL_O and IRQ_O behave per REQ-027 to REQ-029.
REQ-035 When GPI_EDGE_IRQ_EN is undefined, RISE_O, FALL_O and IRQ_O SHALL be tied to 0, EDGE_EN_I and IRQ_CLR_I are ignored, and no edge flops are instantiated.

Verification
REQ-036 Reset scenario: RSTN_I=0 with DI_I=2'b11 and EN_I=1 -> every output is 0; release reset -> IE_O=1 after 1 cycle.
REQ-037 Debounce scenario: SYNC_STAGES=2, N=3, DI_I[0] 0->1 held -> FILT_O=1 exactly 6 cycles later and RISE_O pulses in cycle 7.
REQ-038 Glitch scenario: N=3, 3-cycle high pulse on DI_I[0] -> FILT_O stays 0; 4-cycle pulse -> FILT_O goes to 1.
REQ-039 IRQ scenario: EDGE_EN_I=2'b10, rise then fall -> IRQ_O sets only on the fall; IRQ_CLR_I in the same cycle as a new fall -> IRQ_O stays 1.
REQ-040 Enable scenario: EN_I=0 mid-count (cnt=2) -> IE_O=0 next cycle, cnt=0, FILT_O held; EN_I=1 -> a full N+1 count restarts.
REQ-041 Macro-off scenario: GPI_EDGE_IRQ_EN undefined, toggling input with EDGE_EN_I=2'b11 -> RISE_O, FALL_O and IRQ_O remain 0 while FILT_O still follows.
